// File: rtl/audio_seq_pkg.sv
// Shared types and constants for the audio stream sequencer.
// Optional feature macro: SEQ_ZERO_FILL_EN.
package audio_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ISSUE = 2'd2
  } seq_state_e;

  localparam int DATA_W_DEF   = 16;
  localparam int DIV_44K1_50M = 1134;

endpackage

// File: rtl/audio_stream_sequencer_if.sv
// Stream bundle between sample source, FIR core and result sink.
// master = source/filter/sink side, slave = sequencer side.
interface audio_stream_sequencer_if
  import audio_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              in_tvalid;
  logic              in_tready;
  logic [DATA_W-1:0] in_tdata;
  logic              flt_tvalid;
  logic              flt_tready;
  logic [DATA_W-1:0] flt_tdata;
  logic              res_tvalid;
  logic [DATA_W-1:0] res_tdata;
  logic              out_tvalid;
  logic [DATA_W-1:0] out_tdata;

  modport master (
    output in_tvalid, in_tdata,
    input  in_tready,
    input  flt_tvalid, flt_tdata,
    output flt_tready,
    output res_tvalid, res_tdata,
    input  out_tvalid, out_tdata
  );

  modport slave (
    input  in_tvalid, in_tdata,
    output in_tready,
    output flt_tvalid, flt_tdata,
    input  flt_tready,
    input  res_tvalid, res_tdata,
    output out_tvalid, out_tdata
  );

endinterface

// File: rtl/sample_fifo.sv
// Synchronous FIFO with extra-MSB pointers for exact full/empty.
// Optional feature macro of the enclosing block: SEQ_ZERO_FILL_EN.
module sample_fifo
  import audio_seq_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF,
  parameter int DEPTH = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/audio_stream_sequencer.sv
// Paces buffered audio samples into the FIR core on each sample tick.
// Optional feature macro: SEQ_ZERO_FILL_EN (issue zeros on underrun).
module audio_stream_sequencer
  import audio_seq_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DIV        = DIV_44K1_50M,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    enable,
  audio_stream_sequencer_if.slave bus,
  output logic [15:0]             underrun_cnt,
  output logic                    late_tick,
  output logic                    overrun
);

  seq_state_e        state_q;
  seq_state_e        state_d;
  logic [15:0]       tcnt;
  logic              tick;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              fill0;
  logic              done;
  logic              urun;
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] flt_data_q;
  logic              out_vld_q;
  logic [DATA_W-1:0] out_data_q;

  assign tick = enable && (tcnt == 16'(DIV - 1));
  assign push = bus.in_tvalid && !full;
  assign done = (state_q == ISSUE) && bus.flt_tready;
  assign urun = (state_q == RUN) && tick && empty;

  assign bus.in_tready  = !full;
  assign bus.flt_tvalid = (state_q == ISSUE);
  assign bus.flt_tdata  = flt_data_q;
  assign bus.out_tvalid = out_vld_q;
  assign bus.out_tdata  = out_data_q;

  sample_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (push),
    .din     (bus.in_tdata),
    .pop     (pop),
    .dout    (dout),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    fill0   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (tick) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
`ifdef SEQ_ZERO_FILL_EN
            fill0   = 1'b1;
            state_d = ISSUE;
`else
            state_d = RUN;
`endif
          end
        end else if (!enable) begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (done) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      tcnt         <= '0;
      flt_data_q   <= '0;
      underrun_cnt <= '0;
      late_tick    <= 1'b0;
      overrun      <= 1'b0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q <= state_d;
      if (!enable || tick) tcnt <= '0;
      else                 tcnt <= tcnt + 16'd1;
      if (pop)        flt_data_q <= dout;
      else if (fill0) flt_data_q <= '0;
      if (urun && (underrun_cnt != 16'hFFFF))
        underrun_cnt <= underrun_cnt + 16'd1;
      // a tick during ISSUE is only flagged, never acted on
      if (tick && (state_q == ISSUE)) late_tick <= 1'b1;
      if (bus.in_tvalid && full)      overrun   <= 1'b1;
      out_vld_q <= bus.res_tvalid;
      if (bus.res_tvalid) out_data_q <= bus.res_tdata;
    end
  end

endmodule

// File: tb/tb_audio_stream_sequencer.sv
// Self-checking bench for audio_stream_sequencer (DIV=8, depth 8).
// Honours SEQ_ZERO_FILL_EN in its reference model.
module tb_audio_stream_sequencer;
  import audio_seq_pkg::*;

  localparam int W     = 16;
  localparam int DIV   = 8;
  localparam int DEPTH = 8;

  logic        aclk    = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable  = 1'b0;
  logic [15:0] underrun_cnt;
  logic        late_tick;
  logic        overrun;

  audio_stream_sequencer_if #(.DATA_W(W)) bus ();

  audio_stream_sequencer #(
    .DATA_W     (W),
    .DIV        (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .enable       (enable),
    .bus          (bus),
    .underrun_cnt (underrun_cnt),
    .late_tick    (late_tick),
    .overrun      (overrun)
  );

  always #5 aclk = ~aclk;

  // behavioural reference state
  int          phase;
  bit          busy;
  logic [15:0] cur;
  logic [15:0] q[$];
  int          urun;
  bit          late;
  bit          ovr;
  bit          ov;
  logic [15:0] od;
  int          nassert;
  int          nfail;
  int          nvalid;
  int          rise[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit tick;
    bit hs;
    int sz0;
    hs  = busy && bus.flt_tready;
    sz0 = q.size();
    if (!aresetn) begin
      phase = 0; busy = 0; cur = '0; q.delete();
      urun = 0; late = 0; ovr = 0; ov = 0; od = '0;
    end else begin
      tick  = enable && (phase == DIV - 1);
      phase = (enable && !tick) ? phase + 1 : 0;
      if (bus.in_tvalid && sz0 == DEPTH) ovr = 1;
      if (busy) begin
        if (tick) late = 1;
        if (hs) busy = 0;
      end else if (tick) begin
        if (sz0 > 0) begin
          cur  = q.pop_front();
          busy = 1;
        end else begin
          if (urun < 65535) urun++;
`ifdef SEQ_ZERO_FILL_EN
          cur  = '0;
          busy = 1;
`endif
        end
      end
      if (bus.in_tvalid && sz0 < DEPTH) q.push_back(bus.in_tdata);
      ov = bus.res_tvalid;
      if (bus.res_tvalid) od = bus.res_tdata;
    end
    @(posedge aclk);
    #1;
    chk("flt_tvalid", bus.flt_tvalid, busy);
    chk("flt_tdata", bus.flt_tdata, cur);
    chk("in_tready", bus.in_tready, q.size() < DEPTH);
    chk("underrun_cnt", underrun_cnt, urun);
    chk("late_tick", late_tick, late);
    chk("overrun", overrun, ovr);
    chk("out_tvalid", bus.out_tvalid, ov);
    chk("out_tdata", bus.out_tdata, od);
    if (bus.flt_tvalid) nvalid++;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    enable  = 1'b0;
    bus.in_tvalid  = 1'b0;
    bus.res_tvalid = 1'b0;
    bus.flt_tready = 1'b1;
    repeat (2) step();
    aresetn = 1'b1;
    step();
  endtask

  task automatic push_one(input logic [15:0] d);
    bus.in_tvalid = 1'b1;
    bus.in_tdata  = d;
    step();
    bus.in_tvalid = 1'b0;
  endtask

  initial begin
    nassert = 0;
    nfail   = 0;
    nvalid  = 0;
    bus.in_tvalid  = 1'b0;
    bus.in_tdata   = '0;
    bus.flt_tready = 1'b1;
    bus.res_tvalid = 1'b0;
    bus.res_tdata  = '0;

    // reset state
    do_reset();
    chk("rst_state", dut.state_q, IDLE);
    chk("rst_ready", bus.in_tready, 1);

    // three samples paced one per tick
    push_one(16'h0001);
    push_one(16'h0002);
    push_one(16'h0003);
    enable = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      step();
      if (bus.flt_tvalid) rise.push_back(c);
    end
    chk("t1_rises", rise.size(), 3);
    if (rise.size() == 3) begin
      chk("t1_rise0", rise[0], 8);
      chk("t1_rise1", rise[1], 16);
      chk("t1_rise2", rise[2], 24);
    end
    chk("t1_urun", underrun_cnt, 0);

    // underrun on empty FIFO
    do_reset();
    nvalid = 0;
    enable = 1'b1;
    repeat (4 * DIV) step();
    chk("t2_urun", underrun_cnt, 4);
`ifdef SEQ_ZERO_FILL_EN
    chk("t2_issues", nvalid, 4);
`else
    chk("t2_issues", nvalid, 0);
`endif

    // stalled filter: stable data, late tick, single pop
    do_reset();
    push_one(16'hA5A5);
    push_one(16'h5A5A);
    bus.flt_tready = 1'b0;
    enable = 1'b1;
    repeat (20) step();
    chk("t3_data", bus.flt_tdata, 16'hA5A5);
    chk("t3_late", late_tick, 1);
    chk("t3_ready", bus.in_tready, 1);
    bus.flt_tready = 1'b1;
    repeat (3 * DIV) step();

    // overrun with enable low
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_one(16'($urandom));
    chk("t4_ready", bus.in_tready, 0);
    push_one(16'($urandom));
    chk("t4_ovr", overrun, 1);
    enable = 1'b1;
    repeat ((DEPTH + 1) * DIV) step();

    // result capture back to back
    bus.res_tvalid = 1'b1;
    bus.res_tdata  = 16'h7FFF;
    step();
    chk("t5_v0", bus.out_tvalid, 1);
    chk("t5_d0", bus.out_tdata, 16'h7FFF);
    bus.res_tdata = 16'h8000;
    step();
    chk("t5_v1", bus.out_tvalid, 1);
    chk("t5_d1", bus.out_tdata, 16'h8000);
    bus.res_tvalid = 1'b0;
    step();
    chk("t5_v2", bus.out_tvalid, 0);
    chk("t5_hold", bus.out_tdata, 16'h8000);

    // reset during ISSUE
    do_reset();
    push_one(16'h1234);
    bus.flt_tready = 1'b0;
    enable = 1'b1;
    repeat (10) step();
    chk("t6_pre", bus.flt_tvalid, 1);
    aresetn = 1'b0;
    step();
    chk("t6_vld", bus.flt_tvalid, 0);
    chk("t6_state", dut.state_q, IDLE);
    chk("t6_urun", underrun_cnt, 0);
    chk("t6_late", late_tick, 0);
    chk("t6_ovr", overrun, 0);
    aresetn = 1'b1;
    bus.flt_tready = 1'b1;
    step();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      bus.in_tvalid  = ($urandom_range(0, 99) < 20);
      bus.in_tdata   = 16'($urandom);
      bus.flt_tready = ($urandom_range(0, 99) < 70);
      bus.res_tvalid = ($urandom_range(0, 99) < 30);
      bus.res_tdata  = 16'($urandom);
      if ($urandom_range(0, 99) < 2) enable = ~enable;
      aresetn = ($urandom_range(0, 999) >= 3);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule
